reset_sequencer: RTL and testbench

//   Downstream of the PLL/power-on reset block: takes its resetn and the PLL clock_out and

---
 rtl/reset_sequencer_if.sv | 23 ++
 rtl/reset_sequencer.sv | 136 +++++++++++++
 tb/tb_reset_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and its controlling logic.
// The master drives requests and watchdog control; the slave drives the domain resets and status.
interface reset_sequencer_if;
  logic       resetn_in;
  logic       sw_rst_req;
  logic       wdt_en;
  logic       wdt_kick;
  logic       rst_mem_n;
  logic       rst_periph_n;
  logic       rst_cpu_n;
  logic [1:0] rst_cause;
  logic       wdt_fired;

  modport master (
    output resetn_in, sw_rst_req, wdt_en, wdt_kick,
    input  rst_mem_n, rst_periph_n, rst_cpu_n, rst_cause, wdt_fired
  );

  modport slave (
    input  resetn_in, sw_rst_req, wdt_en, wdt_kick,
    output rst_mem_n, rst_periph_n, rst_cpu_n, rst_cause, wdt_fired
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases memory, peripheral and CPU reset domains in order with a fixed gap, and re-runs the
// sequence on resetn_in drop, watchdog expiry or software request, recording the cause.
//
// state    | meaning
// S_HOLD   | all domains held in reset; waits SW_HOLD cycles and a high resetn_in
// S_MEM    | memory domain released; counting STAGE_DLY cycles
// S_PERIPH | memory and peripheral domains released; counting STAGE_DLY cycles
// S_RUN    | all domains released; watchdog and software reset active
module reset_sequencer #(
  parameter int unsigned STAGE_DLY   = 16,
  parameter int unsigned SW_HOLD     = 8,
  parameter int unsigned WDT_W       = 24,
  parameter int unsigned WDT_TIMEOUT = 12_000_000
) (
  input  logic               clock_out,
  input  logic               reset_ext,
  reset_sequencer_if.slave   io_seq
);

  localparam int unsigned CNT_MAX = (STAGE_DLY > SW_HOLD) ? STAGE_DLY : SW_HOLD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SW_HOLD - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [WDT_W-1:0] WDT_LAST   = WDT_W'(WDT_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_RESETN = 2'b01;
  localparam logic [1:0] CAUSE_WDT    = 2'b10;
  localparam logic [1:0] CAUSE_SW     = 2'b11;

  typedef enum logic [1:0] {S_HOLD, S_MEM, S_PERIPH, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_rsync;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WDT_W-1:0] r_wcnt, w_wcnt_nxt;
  logic [1:0]       r_cause, w_cause_nxt;
  logic             r_wdt_fired, w_fired_nxt;
  logic             r_rst_mem_n, r_rst_periph_n, r_rst_cpu_n;
  logic             w_wdt_cnt_en, w_wdt_exp;

  always_ff @(posedge clock_out or negedge reset_ext) begin
    if (!reset_ext) begin
      r_sync1        <= 1'b0;
      r_rsync        <= 1'b0;
      r_state        <= S_HOLD;
      r_cnt          <= '0;
      r_wcnt         <= '0;
      r_cause        <= 2'b00;
      r_wdt_fired    <= 1'b0;
      r_rst_mem_n    <= 1'b0;
      r_rst_periph_n <= 1'b0;
      r_rst_cpu_n    <= 1'b0;
    end else begin
      r_sync1        <= io_seq.resetn_in;
      r_rsync        <= r_sync1;
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_wcnt         <= w_wcnt_nxt;
      r_cause        <= w_cause_nxt;
      r_wdt_fired    <= w_fired_nxt;
      // Outputs are decoded from the next state so they move on the same edge as the state
      r_rst_mem_n    <= (w_state_nxt != S_HOLD);
      r_rst_periph_n <= (w_state_nxt == S_PERIPH) || (w_state_nxt == S_RUN);
      r_rst_cpu_n    <= (w_state_nxt == S_RUN);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cause_nxt  = r_cause;
    w_fired_nxt  = 1'b0;
    w_cnt_nxt    = r_cnt;
    w_wcnt_nxt   = r_wcnt;
    w_wdt_cnt_en = (r_state == S_RUN) && io_seq.wdt_en;
    w_wdt_exp    = w_wdt_cnt_en && !io_seq.wdt_kick && (r_wcnt == WDT_LAST);

    case (r_state)
      S_HOLD: begin
        if ((r_cnt == HOLD_LAST) && r_rsync) w_state_nxt = S_MEM;
      end
      S_MEM: begin
        if (!r_rsync) begin
          w_state_nxt = S_HOLD;
          w_cause_nxt = CAUSE_RESETN;
        end else if (r_cnt == STAGE_LAST) begin
          w_state_nxt = S_PERIPH;
        end
      end
      S_PERIPH: begin
        if (!r_rsync) begin
          w_state_nxt = S_HOLD;
          w_cause_nxt = CAUSE_RESETN;
        end else if (r_cnt == STAGE_LAST) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!r_rsync) begin
          w_state_nxt = S_HOLD;
          w_cause_nxt = CAUSE_RESETN;
        end else if (w_wdt_exp) begin
          w_state_nxt = S_HOLD;
          w_cause_nxt = CAUSE_WDT;
          w_fired_nxt = 1'b1;
        end else if (io_seq.sw_rst_req) begin
          w_state_nxt = S_HOLD;
          w_cause_nxt = CAUSE_SW;
        end
      end
      default: w_state_nxt = S_HOLD;
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_HOLD:   w_cnt_nxt = (r_cnt == HOLD_LAST) ? r_cnt : r_cnt + CNT_W'(1);
        S_MEM,
        S_PERIPH: w_cnt_nxt = r_cnt + CNT_W'(1);
        default:  w_cnt_nxt = '0;
      endcase
    end

    // Expiry always leaves S_RUN, so the clear below also keeps wcnt from wrapping
    if (!w_wdt_cnt_en || io_seq.wdt_kick || (w_state_nxt != S_RUN)) w_wcnt_nxt = '0;
    else                                                           w_wcnt_nxt = r_wcnt + WDT_W'(1);
  end

  assign io_seq.rst_mem_n    = r_rst_mem_n;
  assign io_seq.rst_periph_n = r_rst_periph_n;
  assign io_seq.rst_cpu_n    = r_rst_cpu_n;
  assign io_seq.rst_cause    = r_cause;
  assign io_seq.wdt_fired    = r_wdt_fired;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up timing, synchroniser latency, watchdog,
// event priority and asynchronous external reset, with hand-computed edge numbers.
module tb_reset_sequencer;
  logic clock_out = 1'b0;
  logic reset_ext = 1'b0;
  int   n_assert  = 0;
  int   n_fail    = 0;

  reset_sequencer_if seq_if ();

  reset_sequencer #(
    .STAGE_DLY  (16),
    .SW_HOLD    (8),
    .WDT_W      (24),
    .WDT_TIMEOUT(100)
  ) dut (
    .clock_out(clock_out),
    .reset_ext(reset_ext),
    .io_seq   (seq_if.slave)
  );

  always #5 clock_out = ~clock_out;

  task automatic step();
    @(posedge clock_out);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic m, input logic p, input logic c,
                         input logic [1:0] cause, input logic fired);
    chk({tag, " mem"},    seq_if.rst_mem_n,    m);
    chk({tag, " periph"}, seq_if.rst_periph_n, p);
    chk({tag, " cpu"},    seq_if.rst_cpu_n,    c);
    chk({tag, " cause"},  seq_if.rst_cause,    cause);
    chk({tag, " fired"},  seq_if.wdt_fired,    fired);
  endtask

  // Steps n edges; each domain is expected high from its release edge onward
  task automatic seq(input string tag, input int n, input int em, input int ep, input int ec,
                     input logic [1:0] cause);
    for (int e = 1; e <= n; e++) begin
      step();
      chk_all($sformatf("%s e%0d", tag, e), e >= em, e >= ep, e >= ec, cause, 1'b0);
    end
  endtask

  initial begin
    seq_if.resetn_in  = 1'b1;
    seq_if.sw_rst_req = 1'b0;
    seq_if.wdt_en     = 1'b0;
    seq_if.wdt_kick   = 1'b0;
    #2;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

    // 1: power-up with resetn_in high
    @(negedge clock_out);
    reset_ext = 1'b1;
    seq("t1", 45, 8, 24, 40, 2'b00);

    // 2: resetn_in low until edge 20
    @(negedge clock_out);
    reset_ext        = 1'b0;
    seq_if.resetn_in = 1'b0;
    #1;
    chk_all("t2 rst", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    @(negedge clock_out);
    reset_ext = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      step();
      if (e == 19) seq_if.resetn_in = 1'b1;
      chk_all($sformatf("t2 e%0d", e), e >= 22, e >= 38, e >= 54, 2'b00, 1'b0);
    end

    // 3: watchdog expiry on the 100th counting edge
    seq_if.wdt_en = 1'b1;
    for (int e = 1; e <= 99; e++) begin
      step();
      chk_all($sformatf("t3 run e%0d", e), 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
    end
    step();
    chk_all("t3 fire", 1'b0, 1'b0, 1'b0, 2'b10, 1'b1);
    seq("t3 reseq", 45, 8, 24, 40, 2'b10);
    seq_if.wdt_en = 1'b0;
    step();
    chk("t3 wcnt clr", dut.r_wcnt, 24'd0);

    // 4: kick every 99 cycles, then kick exactly on the expiry cycle
    seq_if.wdt_en = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      seq_if.wdt_kick = (i % 99 == 0);
      step();
      chk_all($sformatf("t4 i%0d", i), 1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
    end
    seq_if.wdt_kick = 1'b1;
    step();
    seq_if.wdt_kick = 1'b0;
    chk("t4 wcnt kicked", dut.r_wcnt, 24'd0);
    for (int i = 1; i <= 99; i++) step();
    chk("t4 wcnt 99", dut.r_wcnt, 24'd99);
    seq_if.wdt_kick = 1'b1;
    step();
    seq_if.wdt_kick = 1'b0;
    chk_all("t4 kick on expiry", 1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
    chk("t4 wcnt after kick", dut.r_wcnt, 24'd0);
    step();
    chk("t4 wcnt resumes", dut.r_wcnt, 24'd1);
    seq_if.wdt_en = 1'b0;

    // 5: resetn_in drop reaches the FSM on the same edge as sw_rst_req; resetn wins
    seq_if.resetn_in = 1'b0;
    step();
    step();
    chk_all("t5 sync lat", 1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
    seq_if.sw_rst_req = 1'b1;
    step();
    chk_all("t5 both", 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    seq_if.sw_rst_req = 1'b0;
    seq_if.resetn_in  = 1'b1;
    seq("t5 reseq01", 45, 8, 24, 40, 2'b01);
    seq_if.sw_rst_req = 1'b1;
    step();
    seq_if.sw_rst_req = 1'b0;
    chk_all("t5 sw", 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
    seq("t5 reseq11", 45, 8, 24, 40, 2'b11);

    // 6: reset_ext pulse mid-S_PERIPH
    seq_if.sw_rst_req = 1'b1;
    step();
    seq_if.sw_rst_req = 1'b0;
    seq("t6 pre", 30, 8, 24, 40, 2'b11);
    #2;
    reset_ext = 1'b0;
    #1;
    chk_all("t6 async", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    @(negedge clock_out);
    reset_ext = 1'b1;
    seq("t6 powerup", 45, 8, 24, 40, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
